// File: rtl/fridge_cmd_arbiter.sv
// fridge_cmd_arbiter: round-robin two-port command arbiter sequencing the fridge write lines.
// Optional FRIDGE_SHADOW_EN keeps per-target shadows and skips redundant writes.
module fridge_cmd_arbiter #(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 3,
  parameter int FGT_MAX   = 10,
  parameter int FRT_MAX   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [2:0] req0_tgt,
  input  logic [2:0] req1_tgt,
  input  logic [4:0] req0_val,
  input  logic [4:0] req1_val,
  output logic       pwr,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [4:0] inp,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, RELEASE, REJECT, SKIP} state_t;
  state_t st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;
  logic [2:0] tgt_q, tgt_d;
  logic [1:0] sel_q, sel_d;
  logic       s2_q, s2_d, pwr_q, busy_q, done_q, err_q;
  logic [4:0] inp_q, inp_d;
  logic       gnt0, gnt1, acc, legal, skip;
  logic [2:0] a_tgt;
  logic [4:0] a_val;
`ifdef FRIDGE_SHADOW_EN
  logic [4:0] shd_q [5];
  assign skip = legal && shd_q[a_tgt] == a_val;
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 5; i++) shd_q[i] <= '0;
    else if (st_d == RELEASE) shd_q[tgt_q] <= inp_q;
  end
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    gnt1  = st_q == IDLE && power_on && req1_valid && (!req0_valid || ptr_q);
    gnt0  = st_q == IDLE && power_on && req0_valid && !gnt1;
    acc   = gnt0 | gnt1;
    a_tgt = gnt1 ? req1_tgt : req0_tgt;
    a_val = gnt1 ? req1_val : req0_val;
    legal = (a_tgt == 3'd0 && a_val >= 5'd1 && a_val <= 5'(FGT_MAX)) ||
            (a_tgt == 3'd1 && a_val >= 5'd1 && a_val <= 5'(FRT_MAX)) ||
            ((a_tgt == 3'd2 || a_tgt == 3'd3) && a_val <= 5'd3) ||
            (a_tgt == 3'd4 && a_val <= 5'd1);
  end
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    tgt_d = tgt_q;
    inp_d = inp_q;
    s2_d  = s2_q;
    if (st_q == IDLE) begin
      if (acc) begin
        ptr_d = gnt0;
        tgt_d = a_tgt;
        cnt_d = '0;
        st_d  = !legal ? REJECT : skip ? SKIP : SETUP;
        if (legal && !skip) begin
          inp_d = a_val;
          s2_d  = a_tgt == 3'd1 || a_tgt == 3'd3;
        end
      end
    end else if (!power_on) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        SETUP: begin
          st_d  = cnt_q == 8'(SETUP_CYC - 1) ? WRITE : SETUP;
          cnt_d = cnt_q == 8'(SETUP_CYC - 1) ? '0 : cnt_q + 8'd1;
        end
        WRITE: begin
          st_d  = cnt_q == 8'(HOLD_CYC - 1) ? RELEASE : WRITE;
          cnt_d = cnt_q + 8'd1;
        end
        default: st_d = IDLE;
      endcase
    end
    sel_d = st_d == WRITE ? (tgt_q[2] ? 2'b10 : {1'b0, tgt_q[1]}) : 2'b11;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      ptr_q  <= 1'b0;
      tgt_q  <= '0;
      sel_q  <= 2'b11;
      s2_q   <= 1'b0;
      inp_q  <= '0;
      pwr_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      tgt_q  <= tgt_d;
      sel_q  <= sel_d;
      s2_q   <= s2_d;
      inp_q  <= inp_d;
      pwr_q  <= power_on;
      busy_q <= st_d != IDLE;
      done_q <= st_d == RELEASE || st_d == SKIP;
      err_q  <= st_d == REJECT;
    end
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign {s1, s0}   = sel_q;
  assign s2         = s2_q;
  assign inp        = inp_q;
  assign pwr        = pwr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_fridge_cmd_arbiter.sv
// tb_fridge_cmd_arbiter: directed self-checking bench for fridge_cmd_arbiter.
module tb_fridge_cmd_arbiter;
  logic clk = 0, rst = 1, power_on = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [2:0] req0_tgt = 0, req1_tgt = 0;
  logic [4:0] req0_val = 0, req1_val = 0, inp;
  logic pwr, s0, s1, s2, busy, done, err;
  int checks = 0, errors = 0;

  fridge_cmd_arbiter dut (
    .clk(clk), .rst(rst), .power_on(power_on),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_tgt(req0_tgt), .req1_tgt(req1_tgt),
    .req0_val(req0_val), .req1_val(req1_val),
    .pwr(pwr), .s0(s0), .s1(s1), .s2(s2), .inp(inp),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pwr"}, pwr, 0);
    chk({tag, " sel"}, {s1, s0}, 3);
    chk({tag, " s2"}, s2, 0);
    chk({tag, " inp"}, inp, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
  endtask

  // Full write from an IDLE cycle (cycle 0) to the next IDLE cycle (cycle 7).
  task automatic cmd_seq(input string tag, input int w, input int sel, input int s2e, input int v, input bit keep);
    #1;
    chk({tag, " rdy0"}, req0_ready, w == 0);
    chk({tag, " rdy1"}, req1_ready, w == 1);
    tick;
    if (!keep) begin
      req0_valid = 0;
      req1_valid = 0;
    end
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("%s c%0d sel", tag, c), {s1, s0}, (c >= 3 && c <= 5) ? sel : 3);
      chk($sformatf("%s c%0d inp", tag, c), inp, v);
      chk($sformatf("%s c%0d s2", tag, c), s2, s2e);
      chk($sformatf("%s c%0d done", tag, c), done, c == 6);
      chk($sformatf("%s c%0d busy", tag, c), busy, 1);
      tick;
    end
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle done"}, done, 0);
  endtask

  task automatic rej(input string tag, input int t, input int v);
    req0_tgt = 3'(t);
    req0_val = 5'(v);
    req0_valid = 1;
    #1;
    chk({tag, " rdy"}, req0_ready, 1);
    tick;
    req0_valid = 0;
    chk({tag, " err"}, err, 1);
    chk({tag, " sel"}, {s1, s0}, 3);
    chk({tag, " done"}, done, 0);
    chk({tag, " busy"}, busy, 1);
    tick;
    chk({tag, " err2"}, err, 0);
    chk({tag, " busy2"}, busy, 0);
  endtask

  initial begin
    tick;
    tick;
    chk_reset("reset");
    rst = 0;
    power_on = 1;
    req0_tgt = 0; req0_val = 6; req0_valid = 1;
    cmd_seq("wr0", 0, 0, 0, 6, 0);

    rej("rej_t1v25", 1, 25);
    rej("rej_t0v0", 0, 0);
    rej("rej_t2v4", 2, 4);
    rej("rej_t6", 6, 1);

    req0_tgt = 0; req0_val = 9; req0_valid = 1;
    #1;
    chk("abort rdy", req0_ready, 1);
    tick;
    for (int c = 1; c < 4; c++) tick;
    chk("abort c4 sel", {s1, s0}, 0);
    power_on = 0;
    tick;
    chk("abort sel", {s1, s0}, 3);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort pwr", pwr, 0);
    chk("abort rdy_off", req0_ready, 0);
    tick;
    chk("abort done2", done, 0);
    chk("abort rdy_off2", req0_ready, 0);
    req0_valid = 0;
    power_on = 1;
    tick;
    chk("pwr back", pwr, 1);

    req0_tgt = 2; req0_val = 1; req0_valid = 1;
    #1;
    chk("rst rdy", req0_ready, 1);
    tick;
    req0_valid = 0;
    chk("rst setup busy", busy, 1);
    rst = 1;
    tick;
    chk_reset("rst mid");
    rst = 0;

    req0_tgt = 3; req0_val = 2; req0_valid = 1;
    req1_tgt = 1; req1_val = 20; req1_valid = 1;
    cmd_seq("rr0", 0, 1, 1, 2, 1);
    cmd_seq("rr1", 1, 0, 1, 20, 1);
    cmd_seq("rr2", 0, 1, 1, 2, 1);
    cmd_seq("rr3", 1, 0, 1, 20, 0);

    req0_tgt = 4; req0_val = 1; req0_valid = 1;
    cmd_seq("ice1", 0, 2, 0, 1, 0);
    req0_valid = 1;
`ifdef FRIDGE_SHADOW_EN
    #1;
    chk("ice2 rdy", req0_ready, 1);
    tick;
    req0_valid = 0;
    chk("ice2 done", done, 1);
    chk("ice2 sel", {s1, s0}, 3);
    tick;
    chk("ice2 idle", busy, 0);
    chk("ice2 done2", done, 0);
`else
    cmd_seq("ice2", 0, 2, 0, 1, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
